io_port_master: RTL and testbench

Processor-side initiator for the I/O channel protocol served by the I/O device model. It converts a held CPU IN/OUT request into a one-cycle `read_req`/`write_req` pulse on the device channel and waits for the matching ack. It then returns captured read data, or a timeout indication, to the CPU. It stalls the CPU pipeline for the whole transaction and sits between the execution unit and the I/O devices block.

---
 rtl/io_port_master.sv | 142 ++++++++++++++
 tb/tb_io_port_master.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_master.sv
// Processor-side I/O channel initiator: turns a held CPU IN/OUT request into a
// single-cycle device request, waits for the matching ack or a timeout, and stalls the CPU meanwhile.
module io_port_master #(
    parameter int D_WIDTH  = 34,
    parameter int PA_WIDTH = 4,
    parameter int TIMEOUT  = 16
) (
    input  logic                clk,
    input  logic                reset_n_i,
    input  logic                cpu_rd_i,
    input  logic                cpu_wr_i,
    input  logic [PA_WIDTH-1:0] cpu_addr_i,
    input  logic [D_WIDTH-1:0]  cpu_data_i,
    output logic [D_WIDTH-1:0]  cpu_data_o,
    output logic                cpu_stall_o,
    output logic                cpu_done_o,
    output logic                cpu_timeout_o,
    output logic                err_o,
    output logic                read_req_o,
    output logic                write_req_o,
    output logic [PA_WIDTH-1:0] read_addr_o,
    output logic [PA_WIDTH-1:0] write_addr_o,
    output logic [D_WIDTH-1:0]  dout_o,
    input  logic [D_WIDTH-1:0]  din_i,
    input  logic                read_ack_i,
    input  logic                write_ack_i
);

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    state_t        state, state_next;
    logic          is_rd;
    logic          timed_out;
    logic [CW-1:0] cnt;
    logic          accept;
    logic          busy;
    logic          ack_match;
    logic          ack_wrong;
    logic          timeout_hit;

    assign busy        = (state == REQ) || (state == WAIT);
    assign ack_match   = is_rd ? read_ack_i : write_ack_i;
    assign ack_wrong   = is_rd ? write_ack_i : read_ack_i;
    assign cpu_done_o  = (state == DONE);
    assign cpu_timeout_o = cpu_done_o & timed_out;
    assign cpu_stall_o = (cpu_rd_i | cpu_wr_i) & ~cpu_done_o;

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            IDLE: begin
                if (cpu_rd_i || cpu_wr_i) begin
                    accept     = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                state_next = ack_match ? DONE : WAIT;
            end
            WAIT: begin
                if (ack_match) begin
                    state_next = DONE;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    timeout_hit = 1'b1;
                    state_next  = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: request pulses, latched addresses/data, wait counter and result capture.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            is_rd        <= 1'b0;
            timed_out    <= 1'b0;
            cnt          <= '0;
            read_req_o   <= 1'b0;
            write_req_o  <= 1'b0;
            read_addr_o  <= '0;
            write_addr_o <= '0;
            dout_o       <= '0;
            cpu_data_o   <= '0;
            err_o        <= 1'b0;
        end else begin
            read_req_o  <= 1'b0;
            write_req_o <= 1'b0;
            if (accept) begin
                is_rd     <= cpu_rd_i;
                timed_out <= 1'b0;
                if (cpu_rd_i) begin
                    read_addr_o <= cpu_addr_i;
                    read_req_o  <= 1'b1;
                end else begin
                    write_addr_o <= cpu_addr_i;
                    dout_o       <= cpu_data_i;
                    write_req_o  <= 1'b1;
                end
            end
            if (state == REQ) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (busy && ack_match && is_rd) begin
                cpu_data_o <= din_i;
            end
            if (timeout_hit) begin
                timed_out <= 1'b1;
                if (is_rd) begin
                    cpu_data_o <= '1;
                end
            end
            // Stray acks and conflicting requests are sticky until reset.
            if ((state == IDLE || state == DONE) && (read_ack_i || write_ack_i)) begin
                err_o <= 1'b1;
            end
            if (busy && ack_wrong) begin
                err_o <= 1'b1;
            end
            if (state == IDLE && cpu_rd_i && cpu_wr_i) begin
                err_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_port_master.sv
// Directed self-checking bench for io_port_master; completions are checked
// against a scoreboard of expected results pushed when each request is driven.
module tb_io_port_master;

    localparam int DW = 34;
    localparam int AW = 4;
    localparam int TO = 16;

    logic          clk;
    logic          reset_n_i;
    logic          cpu_rd_i;
    logic          cpu_wr_i;
    logic [AW-1:0] cpu_addr_i;
    logic [DW-1:0] cpu_data_i;
    logic [DW-1:0] cpu_data_o;
    logic          cpu_stall_o;
    logic          cpu_done_o;
    logic          cpu_timeout_o;
    logic          err_o;
    logic          read_req_o;
    logic          write_req_o;
    logic [AW-1:0] read_addr_o;
    logic [AW-1:0] write_addr_o;
    logic [DW-1:0] dout_o;
    logic [DW-1:0] din_i;
    logic          read_ack_i;
    logic          write_ack_i;

    typedef struct {
        logic [DW-1:0] data;
        logic          timeout;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;

    io_port_master #(.D_WIDTH(DW), .PA_WIDTH(AW), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .reset_n_i    (reset_n_i),
        .cpu_rd_i     (cpu_rd_i),
        .cpu_wr_i     (cpu_wr_i),
        .cpu_addr_i   (cpu_addr_i),
        .cpu_data_i   (cpu_data_i),
        .cpu_data_o   (cpu_data_o),
        .cpu_stall_o  (cpu_stall_o),
        .cpu_done_o   (cpu_done_o),
        .cpu_timeout_o(cpu_timeout_o),
        .err_o        (err_o),
        .read_req_o   (read_req_o),
        .write_req_o  (write_req_o),
        .read_addr_o  (read_addr_o),
        .write_addr_o (write_addr_o),
        .dout_o       (dout_o),
        .din_i        (din_i),
        .read_ack_i   (read_ack_i),
        .write_ack_i  (write_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pop the next expected completion and compare it with what the DUT presents.
    task automatic check_done(input string tag);
        exp_t e;
        check_output({tag, "_done"}, 64'(cpu_done_o), 64'd1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
        end else begin
            e = sb.pop_front();
            check_output({tag, "_data"}, 64'(cpu_data_o), 64'(e.data));
            check_output({tag, "_timeout"}, 64'(cpu_timeout_o), 64'(e.timeout));
        end
    endtask

    // Full read against a device that acks one cycle after the request.
    task automatic apply_stimulus(input logic [AW-1:0] addr, input logic [DW-1:0] word, input string tag);
        exp_t e;
        e.data = word;
        e.timeout = 1'b0;
        sb.push_back(e);
        cpu_rd_i   = 1'b1;
        cpu_addr_i = addr;
        tick;
        check_output({tag, "_req"}, 64'(read_req_o), 64'd1);
        check_output({tag, "_addr"}, 64'(read_addr_o), 64'(addr));
        tick;
        read_ack_i = 1'b1;
        din_i      = word;
        tick;
        read_ack_i = 1'b0;
        check_done(tag);
        cpu_rd_i = 1'b0;
    endtask

    initial begin
        exp_t e;
        int   n;
        int   last_done;
        logic [DW-1:0] words [5];

        reset_n_i  = 1'b0;
        cpu_rd_i   = 1'b0;
        cpu_wr_i   = 1'b0;
        cpu_addr_i = '0;
        cpu_data_i = '0;
        din_i      = '0;
        read_ack_i = 1'b0;
        write_ack_i = 1'b0;
        words[0] = 34'h0_0000_0011;
        words[1] = 34'h3_FFFF_0000;
        words[2] = 34'h1_2345_6789;
        words[3] = 34'h0_0000_0000;
        words[4] = 34'h2_AAAA_5555;

        tick;
        tick;
        check_output("rst_data", 64'(cpu_data_o), 64'd0);
        check_output("rst_dout", 64'(dout_o), 64'd0);
        check_output("rst_addrs", {read_addr_o, write_addr_o}, 64'd0);
        check_output("rst_reqs", {read_req_o, write_req_o}, 64'd0);
        check_output("rst_done_to_err", {cpu_done_o, cpu_timeout_o, err_o}, 64'd0);
        check_output("rst_stall", 64'(cpu_stall_o), 64'd0);
        reset_n_i = 1'b1;
        tick;

        $display("[TB] read ch2");
        e.data = 34'h0_0000_00AB;
        e.timeout = 1'b0;
        sb.push_back(e);
        cpu_rd_i   = 1'b1;
        cpu_addr_i = 4'd2;
        #1;
        check_output("rd_c0_stall", 64'(cpu_stall_o), 64'd1);
        check_output("rd_c0_req", 64'(read_req_o), 64'd0);
        tick;
        check_output("rd_c1_req", {read_req_o, write_req_o}, 64'b10);
        check_output("rd_c1_addr", 64'(read_addr_o), 64'd2);
        check_output("rd_c1_stall", 64'(cpu_stall_o), 64'd1);
        tick;
        check_output("rd_c2_req", 64'(read_req_o), 64'd0);
        check_output("rd_c2_stall", 64'(cpu_stall_o), 64'd1);
        check_output("rd_c2_done", 64'(cpu_done_o), 64'd0);
        read_ack_i = 1'b1;
        din_i      = 34'h0_0000_00AB;
        tick;
        read_ack_i = 1'b0;
        check_done("rd");
        check_output("rd_c3_stall", 64'(cpu_stall_o), 64'd0);
        check_output("rd_err", 64'(err_o), 64'd0);
        cpu_rd_i = 1'b0;
        tick;
        check_output("rd_c4_done", 64'(cpu_done_o), 64'd0);

        $display("[TB] write ch1");
        e.data = 34'h0_0000_00AB;
        e.timeout = 1'b0;
        sb.push_back(e);
        cpu_wr_i   = 1'b1;
        cpu_addr_i = 4'd1;
        cpu_data_i = 34'h3;
        tick;
        check_output("wr_c1_req", {read_req_o, write_req_o}, 64'b01);
        check_output("wr_c1_addr", 64'(write_addr_o), 64'd1);
        check_output("wr_c1_dout", 64'(dout_o), 64'h3);
        check_output("wr_c1_rdaddr_hold", 64'(read_addr_o), 64'd2);
        tick;
        check_output("wr_c2_req", 64'(write_req_o), 64'd0);
        write_ack_i = 1'b1;
        tick;
        write_ack_i = 1'b0;
        check_done("wr");
        cpu_wr_i = 1'b0;
        tick;

        $display("[TB] read timeout");
        e.data = {DW{1'b1}};
        e.timeout = 1'b1;
        sb.push_back(e);
        cpu_rd_i   = 1'b1;
        cpu_addr_i = 4'd5;
        tick;
        check_output("to_req", 64'(read_req_o), 64'd1);
        n = 1;
        while (!cpu_done_o && n < 40) begin
            tick;
            n++;
        end
        check_output("to_cycle", 64'(n), 64'(2 + TO));
        check_done("to");
        cpu_rd_i = 1'b0;
        tick;
        check_output("to_err_before", 64'(err_o), 64'd0);
        tick;
        read_ack_i = 1'b1;
        tick;
        read_ack_i = 1'b0;
        check_output("late_ack_err", 64'(err_o), 64'd1);
        check_output("late_ack_idle", {cpu_done_o, read_req_o, write_req_o}, 64'd0);
        tick;
        check_output("late_ack_idle2", {cpu_done_o, read_req_o, write_req_o}, 64'd0);

        $display("[TB] reset during wait");
        cpu_rd_i   = 1'b1;
        cpu_addr_i = 4'd7;
        tick;
        tick;
        tick;
        reset_n_i = 1'b0;
        #1;
        check_output("mid_rst_reqs", {read_req_o, write_req_o}, 64'd0);
        check_output("mid_rst_addrs", {read_addr_o, write_addr_o}, 64'd0);
        check_output("mid_rst_data", {cpu_data_o, dout_o}, 64'd0);
        check_output("mid_rst_flags", {cpu_done_o, cpu_timeout_o, err_o}, 64'd0);
        check_output("mid_rst_stall", 64'(cpu_stall_o), 64'd1);
        cpu_rd_i = 1'b0;
        tick;
        reset_n_i = 1'b1;
        tick;
        check_output("post_rst_done", 64'(cpu_done_o), 64'd0);
        tick;
        check_output("post_rst_done2", 64'(cpu_done_o), 64'd0);
        apply_stimulus(4'd3, 34'h0_0000_0155, "fresh");
        tick;

        $display("[TB] simultaneous rd and wr");
        e.data = 34'h1_0000_02A5;
        e.timeout = 1'b0;
        sb.push_back(e);
        cpu_rd_i   = 1'b1;
        cpu_wr_i   = 1'b1;
        cpu_addr_i = 4'd4;
        cpu_data_i = 34'h2_0000_0077;
        tick;
        check_output("both_req", {read_req_o, write_req_o}, 64'b10);
        check_output("both_err", 64'(err_o), 64'd1);
        check_output("both_dout", 64'(dout_o), 64'd0);
        check_output("both_addr", 64'(read_addr_o), 64'd4);
        tick;
        write_ack_i = 1'b1;
        tick;
        write_ack_i = 1'b0;
        check_output("both_wrong_ack_ignored", 64'(cpu_done_o), 64'd0);
        check_output("both_no_wreq", 64'(write_req_o), 64'd0);
        read_ack_i = 1'b1;
        din_i      = 34'h1_0000_02A5;
        tick;
        read_ack_i = 1'b0;
        check_done("both");
        cpu_rd_i = 1'b0;
        cpu_wr_i = 1'b0;
        tick;

        $display("[TB] back-to-back reads");
        last_done = 0;
        for (int i = 0; i < 5; i++) begin
            e.data = words[i];
            e.timeout = 1'b0;
            sb.push_back(e);
            cpu_rd_i   = 1'b1;
            cpu_addr_i = AW'(i + 8);
            tick;
            check_output("b2b_req", 64'(read_req_o), 64'd1);
            read_ack_i = 1'b1;
            din_i      = words[i];
            tick;
            read_ack_i = 1'b0;
            check_done("b2b");
            if (i > 0) begin
                check_output("b2b_spacing", 64'(cyc - last_done), 64'd3);
            end
            last_done = cyc;
            cpu_rd_i = 1'b0;
            tick;
        end
        check_output("sb_empty", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
